// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_addr_gen
// Purpose  : Expands one AXI AW/AR-style request (addr, len, size, burst, id)
//            into a per-beat descriptor stream: beat address, byte-lane
//            strobe, beat index and last flag. Supports FIXED, INCR and WRAP
//            bursts; illegal requests are dropped with a one-cycle err pulse.
// Options  : AXI_4K_CHECK_EN - when defined, INCR bursts crossing a 4 KB page
//            boundary are treated as illegal (constant false when
//            ADDR_WIDTH < 13).
// Ports    : axi_tb_ACLK   - clock
//            axi_tb_ARESET - synchronous active-high reset
//            req_*         - request channel (valid/ready handshake)
//            beat_*        - beat descriptor channel (valid/ready handshake)
//            err           - one-cycle pulse, illegal request dropped
//            busy          - burst in progress
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = 8,
    parameter int SIZE_WIDTH   = 3,
    parameter int BURST_WIDTH  = 2,
    parameter int ID_WIDTH     = 4,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    axi_tb_ACLK,
    input  logic                    axi_tb_ARESET,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ID_WIDTH-1:0]     req_id,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [LEN_WIDTH-1:0]    req_len,
    input  logic [SIZE_WIDTH-1:0]   req_size,
    input  logic [BURST_WIDTH-1:0]  req_burst,
    output logic                    beat_valid,
    input  logic                    beat_ready,
    output logic [ID_WIDTH-1:0]     beat_id,
    output logic [ADDR_WIDTH-1:0]   beat_addr,
    output logic [STROBE_WIDTH-1:0] beat_strb,
    output logic [LEN_WIDTH-1:0]    beat_idx,
    output logic                    beat_last,
    output logic                    err,
    output logic                    busy
);

    localparam logic [BURST_WIDTH-1:0] C_FIXED    = BURST_WIDTH'(0);
    localparam logic [BURST_WIDTH-1:0] C_INCR     = BURST_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] C_WRAP     = BURST_WIDTH'(2);
    localparam logic [BURST_WIDTH-1:0] C_RSVD     = BURST_WIDTH'(3);
    // Largest legal AxSIZE: a beat may not be wider than the data bus.
    localparam logic [SIZE_WIDTH-1:0]  C_MAX_SIZE = SIZE_WIDTH'($clog2(STROBE_WIDTH));
    // Mask selecting the byte-lane part of an address.
    localparam logic [ADDR_WIDTH-1:0]  C_LANE_MASK = ADDR_WIDTH'(STROBE_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_req_ready;
    logic                    r_beat_valid;
    logic [ID_WIDTH-1:0]     r_beat_id;
    logic [ADDR_WIDTH-1:0]   r_beat_addr;
    logic [STROBE_WIDTH-1:0] r_beat_strb;
    logic [LEN_WIDTH-1:0]    r_beat_idx;
    logic                    r_beat_last;
    logic                    r_err;
    logic                    r_busy;
    // Latched request fields used while the burst runs.
    logic [ADDR_WIDTH-1:0]   r_start;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [SIZE_WIDTH-1:0]   r_size;
    logic [BURST_WIDTH-1:0]  r_burst;

    // ------------------------------------------------------------------
    // Byte-lane strobe for a beat at address a with 2^sz bytes per beat.
    // Lanes run from the address lane up to the end of the aligned beat,
    // which trims the leading lanes of an unaligned first INCR beat.
    // ------------------------------------------------------------------
    function automatic logic [STROBE_WIDTH-1:0] f_strb(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [SIZE_WIDTH-1:0] sz
    );
        logic [ADDR_WIDTH-1:0] v_bmask;
        logic [ADDR_WIDTH-1:0] v_lo;
        logic [ADDR_WIDTH-1:0] v_hi;
        v_bmask = (ADDR_WIDTH'(1) << sz) - ADDR_WIDTH'(1);
        v_lo    = a & C_LANE_MASK;
        v_hi    = (a & ~v_bmask & C_LANE_MASK) + v_bmask;
        for (int i = 0; i < STROBE_WIDTH; i++) begin
            f_strb[i] = (ADDR_WIDTH'(i) >= v_lo) && (ADDR_WIDTH'(i) <= v_hi);
        end
    endfunction

    // ------------------------------------------------------------------
    // Request legality check (evaluated on the incoming request fields)
    // ------------------------------------------------------------------
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_req_bmask;
    logic                  w_size_bad;
    logic                  w_wrap_len_ok;
    logic                  w_wrap_bad;
    logic                  w_4k_cross;
    logic                  w_illegal;

    assign w_accept      = req_valid && r_req_ready;
    assign w_req_bmask   = (ADDR_WIDTH'(1) << req_size) - ADDR_WIDTH'(1);
    assign w_size_bad    = req_size > C_MAX_SIZE;
    assign w_wrap_len_ok = (req_len == LEN_WIDTH'(1)) || (req_len == LEN_WIDTH'(3)) ||
                           (req_len == LEN_WIDTH'(7)) || (req_len == LEN_WIDTH'(15));
    assign w_wrap_bad    = (req_burst == C_WRAP) &&
                           (!w_wrap_len_ok || ((req_addr & w_req_bmask) != '0));
    assign w_illegal     = (req_burst == C_RSVD) || w_size_bad || w_wrap_bad || w_4k_cross;

`ifdef AXI_4K_CHECK_EN
    generate
        if (ADDR_WIDTH >= 13) begin : g_4k_chk
            // Extended width so the byte count and end address never overflow
            // before the page comparison; running past the top of the address
            // space therefore also counts as a page crossing.
            localparam int C_EXT = ADDR_WIDTH + LEN_WIDTH + 8;
            logic [C_EXT-1:0] w_start_al;
            logic [C_EXT-1:0] w_bytes;
            logic [C_EXT-1:0] w_last_byte;
            assign w_start_al  = C_EXT'(req_addr & ~w_req_bmask);
            assign w_bytes     = (C_EXT'(req_len) + C_EXT'(1)) << req_size;
            assign w_last_byte = w_start_al + w_bytes - C_EXT'(1);
            assign w_4k_cross  = (req_burst == C_INCR) &&
                                 ((w_last_byte >> 12) != (C_EXT'(req_addr) >> 12));
        end else begin : g_4k_off
            assign w_4k_cross = 1'b0;
        end
    endgenerate
`else
    assign w_4k_cross = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-beat address arithmetic (from the currently presented beat)
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_b;
    logic [ADDR_WIDTH-1:0] w_bmask;
    logic [ADDR_WIDTH-1:0] w_incr_nxt;
    logic [ADDR_WIDTH-1:0] w_wrap_bytes;
    logic [ADDR_WIDTH-1:0] w_wrap_lo;
    logic [ADDR_WIDTH-1:0] w_wrap_sum;
    logic [ADDR_WIDTH-1:0] w_wrap_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [LEN_WIDTH-1:0]  w_idx_nxt;

    assign w_b          = ADDR_WIDTH'(1) << r_size;
    assign w_bmask      = w_b - ADDR_WIDTH'(1);
    // INCR realigns after the first beat, so an unaligned start only
    // affects beat 0. Overflow wraps silently at the top of the space.
    assign w_incr_nxt   = (r_beat_addr & ~w_bmask) + w_b;
    // WRAP window: total burst bytes, aligned down from the start address.
    assign w_wrap_bytes = (ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size;
    assign w_wrap_lo    = r_start & ~(w_wrap_bytes - ADDR_WIDTH'(1));
    assign w_wrap_sum   = r_beat_addr + w_b;
    assign w_wrap_nxt   = (w_wrap_sum == (w_wrap_lo + w_wrap_bytes)) ? w_wrap_lo : w_wrap_sum;
    assign w_idx_nxt    = r_beat_idx + LEN_WIDTH'(1);

    always_comb begin
        w_addr_nxt = r_beat_addr;
        case (r_burst)
            C_FIXED: w_addr_nxt = r_beat_addr;
            C_INCR:  w_addr_nxt = w_incr_nxt;
            C_WRAP:  w_addr_nxt = w_wrap_nxt;
            default: w_addr_nxt = r_beat_addr;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge axi_tb_ACLK) begin
        if (axi_tb_ARESET) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_beat_valid <= 1'b0;
            r_beat_id    <= '0;
            r_beat_addr  <= '0;
            r_beat_strb  <= '0;
            r_beat_idx   <= '0;
            r_beat_last  <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_start      <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_err <= 1'b0;
                    if (w_accept) begin
                        r_start     <= req_addr;
                        r_len       <= req_len;
                        r_size      <= req_size;
                        r_burst     <= req_burst;
                        r_beat_id   <= req_id;
                        r_req_ready <= 1'b0;
                        if (w_illegal) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state      <= S_BURST;
                            r_busy       <= 1'b1;
                            r_beat_valid <= 1'b1;
                            r_beat_addr  <= req_addr;
                            r_beat_strb  <= f_strb(req_addr, req_size);
                            r_beat_idx   <= '0;
                            r_beat_last  <= (req_len == '0);
                        end
                    end
                end
                S_BURST: begin
                    if (beat_ready) begin
                        if (r_beat_last) begin
                            // Return to idle; req_ready rises only after
                            // this edge, so no same-cycle re-accept.
                            r_state      <= S_IDLE;
                            r_beat_valid <= 1'b0;
                            r_beat_last  <= 1'b0;
                            r_busy       <= 1'b0;
                            r_req_ready  <= 1'b1;
                        end else begin
                            r_beat_addr <= w_addr_nxt;
                            r_beat_strb <= f_strb(w_addr_nxt, r_size);
                            r_beat_idx  <= w_idx_nxt;
                            r_beat_last <= (w_idx_nxt == r_len);
                        end
                    end
                end
                S_ERR: begin
                    r_state     <= S_IDLE;
                    r_err       <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_beat_valid <= 1'b0;
                    r_beat_last  <= 1'b0;
                    r_err        <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign beat_valid = r_beat_valid;
    assign beat_id    = r_beat_id;
    assign beat_addr  = r_beat_addr;
    assign beat_strb  = r_beat_strb;
    assign beat_idx   = r_beat_idx;
    assign beat_last  = r_beat_last;
    assign err        = r_err;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_burst_addr_gen
// Purpose  : Self-checking bench for axi_burst_addr_gen (DATA_WIDTH=32).
//            Expected beats are queued when a request is issued and compared
//            as the generator presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_burst_addr_gen;

    logic        axi_tb_ACLK = 1'b0;
    logic        axi_tb_ARESET;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_id;
    logic [15:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [1:0]  req_burst;
    logic        beat_valid;
    logic        beat_ready;
    logic [3:0]  beat_id;
    logic [15:0] beat_addr;
    logic [3:0]  beat_strb;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic        err;
    logic        busy;

    axi_burst_addr_gen #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .LEN_WIDTH(8), .SIZE_WIDTH(3),
        .BURST_WIDTH(2), .ID_WIDTH(4), .STROBE_WIDTH(4)
    ) dut (
        .axi_tb_ACLK(axi_tb_ACLK), .axi_tb_ARESET(axi_tb_ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
        .req_burst(req_burst), .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_id(beat_id), .beat_addr(beat_addr), .beat_strb(beat_strb),
        .beat_idx(beat_idx), .beat_last(beat_last), .err(err), .busy(busy)
    );

    always #5 axi_tb_ACLK = ~axi_tb_ACLK;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  strb;
        logic [7:0]  idx;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timeout waiting for DUT", tag);
    endtask

    task automatic push(input logic [3:0] id, input logic [15:0] addr,
                        input logic [3:0] strb, input logic [7:0] idx, input logic last);
        beat_t e;
        e.addr = addr; e.strb = strb; e.idx = idx; e.last = last; e.id = id;
        q.push_back(e);
    endtask

    // Reference model: beat n computed directly from the start address.
    task automatic model(input logic [3:0] id, input int addr, input int len,
                         input int size, input int burst);
        int b, w, lower, a, lo, hi;
        logic [3:0] s;
        b     = 1 << size;
        w     = b * (len + 1);
        lower = addr - (addr % w);
        for (int n = 0; n <= len; n++) begin
            if (burst == 0)      a = addr;
            else if (burst == 1) a = (n == 0) ? addr : ((addr - addr % b) + n * b) % 65536;
            else                 a = lower + ((addr - lower + n * b) % w);
            lo = a % 4;
            hi = (a - a % b) % 4 + b - 1;
            s  = 4'b0000;
            for (int l = 0; l < 4; l++) if (l >= lo && l <= hi) s[l] = 1'b1;
            push(id, a[15:0], s, n[7:0], n == len);
        end
    endtask

    // Starts and ends on a negedge; returns half a cycle after the accept edge.
    task automatic send_req(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        while (!req_ready && t < 50) begin
            @(posedge axi_tb_ACLK); @(negedge axi_tb_ACLK); t++;
        end
        if (!req_ready) timeout_fail("req_ready");
        req_valid = 1'b1; req_id = id; req_addr = addr; req_len = len;
        req_size = size; req_burst = burst;
        @(posedge axi_tb_ACLK); @(negedge axi_tb_ACLK);
        req_valid = 1'b0;
    endtask

    // Drains the queue; holds beat_ready low for stall_cycles at stall_idx.
    task automatic consume(input int stall_idx, input int stall_cycles);
        int t = 0;
        int stalls = stall_cycles;
        beat_t e;
        while (q.size() > 0) begin
            if (!beat_valid) begin
                t++;
                if (t > 100) begin
                    timeout_fail("beat_valid");
                    q.delete();
                    break;
                end
            end else begin
                e = q[0];
                check("beat_addr", 32'(beat_addr), 32'(e.addr));
                check("beat_strb", 32'(beat_strb), 32'(e.strb));
                check("beat_idx",  32'(beat_idx),  32'(e.idx));
                check("beat_last", 32'(beat_last), 32'(e.last));
                check("beat_id",   32'(beat_id),   32'(e.id));
                check("busy",      32'(busy),      32'd1);
                if (int'(e.idx) == stall_idx && stalls > 0) begin
                    beat_ready = 1'b0;
                    stalls--;
                end else begin
                    beat_ready = 1'b1;
                    void'(q.pop_front());
                end
            end
            @(posedge axi_tb_ACLK); @(negedge axi_tb_ACLK);
        end
        beat_ready = 1'b0;
        check("end_valid", 32'(beat_valid), 32'd0);
        check("end_busy",  32'(busy),       32'd0);
        check("end_ready", 32'(req_ready),  32'd1);
    endtask

    task automatic err_case(input string tag, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        send_req(4'hE, addr, len, size, burst);
        check({tag, "_err"},   32'(err),        32'd1);
        check({tag, "_valid"}, 32'(beat_valid), 32'd0);
        check({tag, "_ready"}, 32'(req_ready),  32'd0);
        @(posedge axi_tb_ACLK); @(negedge axi_tb_ACLK);
        check({tag, "_err2"},   32'(err),        32'd0);
        check({tag, "_ready2"}, 32'(req_ready),  32'd1);
        check({tag, "_valid2"}, 32'(beat_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        axi_tb_ARESET = 1'b1;
        req_valid = 1'b0; req_id = '0; req_addr = '0; req_len = '0;
        req_size = '0; req_burst = '0; beat_ready = 1'b0;
        repeat (3) @(posedge axi_tb_ACLK);
        @(negedge axi_tb_ACLK);
        check("rst_req_ready", 32'(req_ready),  32'd1);
        check("rst_valid",     32'(beat_valid), 32'd0);
        check("rst_last",      32'(beat_last),  32'd0);
        check("rst_err",       32'(err),        32'd0);
        check("rst_busy",      32'(busy),       32'd0);
        check("rst_addr",      32'(beat_addr),  32'd0);
        check("rst_strb",      32'(beat_strb),  32'd0);
        check("rst_idx",       32'(beat_idx),   32'd0);
        check("rst_id",        32'(beat_id),    32'd0);
        axi_tb_ARESET = 1'b0;
        @(posedge axi_tb_ACLK); @(negedge axi_tb_ACLK);

        // INCR unaligned start: expected values written out explicitly
        push(4'h1, 16'h0102, 4'b1100, 8'd0, 1'b0);
        push(4'h1, 16'h0104, 4'b1111, 8'd1, 1'b0);
        push(4'h1, 16'h0108, 4'b1111, 8'd2, 1'b0);
        push(4'h1, 16'h010C, 4'b1111, 8'd3, 1'b1);
        send_req(4'h1, 16'h0102, 8'd3, 3'd2, 2'b01);
        check("latency1_valid", 32'(beat_valid), 32'd1);
        consume(-1, 0);

        // WRAP wrapping back to the window base
        push(4'h2, 16'h0038, 4'b1111, 8'd0, 1'b0);
        push(4'h2, 16'h003C, 4'b1111, 8'd1, 1'b0);
        push(4'h2, 16'h0030, 4'b1111, 8'd2, 1'b0);
        push(4'h2, 16'h0034, 4'b1111, 8'd3, 1'b1);
        send_req(4'h2, 16'h0038, 8'd3, 3'd2, 2'b10);
        consume(-1, 0);

        // Illegal requests
        err_case("wrap_len2",  16'h0038, 8'd2, 3'd2, 2'b10);
        err_case("wrap_unal",  16'h0032, 8'd3, 3'd2, 2'b10);
        err_case("burst_rsvd", 16'h0000, 8'd1, 3'd0, 2'b11);
        err_case("size3",      16'h0000, 8'd1, 3'd3, 2'b01);

        // FIXED byte burst
        model(4'h3, 16'h0011, 2, 0, 0);
        send_req(4'h3, 16'h0011, 8'd2, 3'd0, 2'b00);
        consume(-1, 0);

        // Backpressure: stall 3 cycles at idx 1
        model(4'h4, 16'h0000, 3, 2, 1);
        send_req(4'h4, 16'h0000, 8'd3, 3'd2, 2'b01);
        consume(1, 3);

        // Single beat, halfword at the top lane
        model(4'h7, 16'h0123, 0, 1, 1);
        send_req(4'h7, 16'h0123, 8'd0, 3'd1, 2'b01);
        consume(-1, 0);

        // WRAP with halfword beats, len 7
        model(4'h8, 16'h0046, 7, 1, 2);
        send_req(4'h8, 16'h0046, 8'd7, 3'd1, 2'b10);
        consume(-1, 0);

        // Reset in the middle of an 8-beat burst
        send_req(4'h5, 16'h0000, 8'd7, 3'd2, 2'b01);
        beat_ready = 1'b1;
        t = 0;
        while (!(beat_valid && beat_idx == 8'd2) && t < 20) begin
            @(posedge axi_tb_ACLK); @(negedge axi_tb_ACLK); t++;
        end
        if (t >= 20) timeout_fail("reach_idx2");
        check("pre_rst_addr", 32'(beat_addr), 32'h0008);
        axi_tb_ARESET = 1'b1;
        @(posedge axi_tb_ACLK); @(negedge axi_tb_ACLK);
        axi_tb_ARESET = 1'b0;
        beat_ready = 1'b0;
        check("mid_rst_valid", 32'(beat_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready),  32'd1);
        check("mid_rst_busy",  32'(busy),       32'd0);
        check("mid_rst_err",   32'(err),        32'd0);
        check("mid_rst_idx",   32'(beat_idx),   32'd0);
        check("mid_rst_addr",  32'(beat_addr),  32'd0);
        model(4'h6, 16'h0200, 1, 2, 1);
        send_req(4'h6, 16'h0200, 8'd1, 3'd2, 2'b01);
        consume(-1, 0);

        // 4 KB page crossing
`ifdef AXI_4K_CHECK_EN
        err_case("cross_4k", 16'h0FF8, 8'd3, 3'd2, 2'b01);
`else
        push(4'h9, 16'h0FF8, 4'b1111, 8'd0, 1'b0);
        push(4'h9, 16'h0FFC, 4'b1111, 8'd1, 1'b0);
        push(4'h9, 16'h1000, 4'b1111, 8'd2, 1'b0);
        push(4'h9, 16'h1004, 4'b1111, 8'd3, 1'b1);
        send_req(4'h9, 16'h0FF8, 8'd3, 3'd2, 2'b01);
        consume(-1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_burst_addr_gen.md
Name: axi_burst_addr_gen

Overview:
Parametrised AXI burst address generator shared by the AXI driver, monitor and slave model. It accepts one AW/AR-style request (addr, len, size, burst, id) and expands it into a per-beat stream. Each beat carries the beat address, byte-lane mask, beat index and last flag. It covers FIXED, INCR and WRAP bursts and flags illegal requests.

Parameters:
ADDR_WIDTH, 16, address bus width
DATA_WIDTH, 32, data bus width in bits (8..1024, power of 2)
LEN_WIDTH, 8, AxLEN width; beats = len+1
SIZE_WIDTH, 3, AxSIZE width; bytes/beat = 2^size
BURST_WIDTH, 2, AxBURST width
ID_WIDTH, 4, transaction ID width
STROBE_WIDTH, DATA_WIDTH/8, byte lanes

Ports:
axi_tb_ACLK  in  1  clock
axi_tb_ARESET  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  generator idle, can accept
req_id  in  ID_WIDTH  request ID
req_addr  in  ADDR_WIDTH  start address
req_len  in  LEN_WIDTH  beats-1
req_size  in  SIZE_WIDTH  log2 bytes/beat
req_burst  in  BURST_WIDTH  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
beat_valid  out  1  beat descriptor valid
beat_ready  in  1  consumer takes beat
beat_id  out  ID_WIDTH  ID of current burst
beat_addr  out  ADDR_WIDTH  beat address
beat_strb  out  STROBE_WIDTH  active byte lanes
beat_idx  out  LEN_WIDTH  beat number, 0-based
beat_last  out  1  final beat of burst
err  out  1  one-cycle pulse: illegal request dropped
busy  out  1  burst in progress

Behaviour:
- Interface decision: single clock axi_tb_ACLK; reset axi_tb_ARESET is synchronous and active-high.
- Reset values: req_ready=1, beat_valid=0, beat_last=0, err=0, busy=0; beat_addr, beat_strb, beat_idx and beat_id = 0.
- FSM states: IDLE, BURST, ERR.
- IDLE: req_ready=1. On req_valid and req_ready, latch all request fields and run the legality check.
  - Legal request: go to BURST.
  - Illegal request: go to ERR.
- Illegal request means any of:
  - burst = 11;
  - 2^size > STROBE_WIDTH;
  - WRAP with len not in {1,3,7,15};
  - WRAP with addr not aligned to 2^size.
- ERR: lasts one cycle. err=1, no beats issued, then go to IDLE.
- BURST: req_ready=0, busy=1, beat_valid=1.
  - Beat 0 appears the cycle after acceptance (latency 1).
  - A beat advances on beat_valid and beat_ready.
  - All beat outputs stay stable while beat_valid=1 and beat_ready=0.
- Last beat: beat_last=1 when beat_idx equals the latched len. On its handshake, beat_valid drops and the FSM returns to IDLE. req_ready rises the next cycle; there is no same-cycle re-accept.
- Address arithmetic uses B = 2^size and aligned(a) = a & ~(B-1).
  - FIXED: every beat = start addr.
  - INCR: beat0 = start addr (unaligned allowed); beat n+1 = aligned(beat n) + B, modulo 2^ADDR_WIDTH (silent wrap at top of address space).
  - WRAP: W = B*(len+1), lower = addr & ~(W-1). next = beat n + B; if next == lower + W, next = lower.
- Strobe for beat address a: lo = a mod STROBE_WIDTH, hi = (aligned(a) mod STROBE_WIDTH) + B - 1. Lanes lo..hi are set; all others are 0.
- len = 0 produces a single beat with beat_last=1.
- Reset asserted mid-burst: the next cycle is IDLE with reset values. The partial burst is abandoned and no err is raised.
- Reset has priority over every handshake in the same cycle.

Optional Feature:
- Macro: AXI_4K_CHECK_EN.
- Defined: an INCR request whose last byte, (aligned(addr) + B*(len+1) - 1), lies in a different 4 KB page than addr is illegal. It takes the ERR path: err pulse, no beats.
- Defined, ADDR_WIDTH < 13: the check is constant false.
- Undefined: no 4 KB check; crossing bursts are generated normally.

Test Plan:
All cases use DATA_WIDTH=32.
- INCR addr 0x0102, size 2, len 3 -> addrs 0x0102, 0x0104, 0x0108, 0x010C; strb 1100, 1111, 1111, 1111; beat_last only on idx 3; first beat_valid 1 cycle after accept.
- WRAP addr 0x0038, size 2, len 3 -> 0x0038, 0x003C, 0x0030, 0x0034, all strb 1111. WRAP len 2 -> err pulse for 1 cycle, no beat_valid, req_ready back high within 2 cycles.
- FIXED addr 0x0011, size 0, len 2 -> three beats at 0x0011, strb 0010, idx 0, 1, 2. Burst 11 -> err, no beats. Size 3 -> err.
- Backpressure: INCR 0x0000, size 2, len 3; hold beat_ready=0 for 3 cycles at idx 1 -> addr 0x0004, strb and idx held constant; then 0x0008 follows the next handshake.
- Reset: assert axi_tb_ARESET at idx 2 of an 8-beat burst -> next cycle beat_valid=0, req_ready=1, busy=0, err=0; the next request starts at idx 0.
- 4 KB: INCR 0x0FF8, size 2, len 3 -> with AXI_4K_CHECK_EN, err and no beats; without it, 0x0FF8, 0x0FFC, 0x1000, 0x1004.
